// File: rtl/fetch_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_param
// Brief    : Parametrised IF stage: PC register, next-PC select, IF/ID register
//            and a 1-cycle synchronous instruction memory interface.
//            Optional perf counters are enabled by defining FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage_param #(
    parameter int unsigned   AW        = 27,
    parameter int unsigned   IW        = 27,
    parameter logic [AW-1:0] PC_STEP   = AW'(1),
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter logic [IW-1:0] NOP_INSTR = '0
`ifdef FETCH_PERF_EN
    ,
    parameter int unsigned   CNT_W     = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcE,
    input  logic [AW-1:0]    PCTargetE,
    output logic [AW-1:0]    imem_addr,
    input  logic [IW-1:0]    imem_data,
    output logic [IW-1:0]    InstrD,
    output logic [AW-1:0]    PCD,
    output logic [AW-1:0]    PCPlus4D,
    output logic             ValidD,
    output logic [AW-1:0]    PCF_debug,
    output logic [IW-1:0]    InstrF_debug
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_fetched,
    output logic [CNT_W-1:0] perf_flushed,
    output logic [CNT_W-1:0] perf_stalled
`endif
);

    logic [AW-1:0] pcf_q;
    logic [AW-1:0] pcf_d;
    logic          boot_q;
    logic [IW-1:0] instrd_q;
    logic [IW-1:0] instrd_d;
    logic [AW-1:0] pcd_q;
    logic [AW-1:0] pcd_d;
    logic [AW-1:0] pcplus_q;
    logic [AW-1:0] pcplus_d;
    logic          validd_q;
    logic          validd_d;

    logic [AW-1:0] pcf_plus;
    logic          fvalid;
    logic          flush_take;
    logic          load_take;

    // Boot cycle re-presents RESET_PC so the first instruction is fetched, not skipped.
    always_comb begin
        pcf_plus = pcf_q + PC_STEP;
        if (PCSrcE) begin
            pcf_d = PCTargetE;
        end else if (boot_q || StallF) begin
            pcf_d = pcf_q;
        end else begin
            pcf_d = pcf_plus;
        end
    end

    assign imem_addr = rst ? pcf_d : RESET_PC;
    assign fvalid    = !boot_q && !PCSrcE;

    always_comb begin
        instrd_d   = instrd_q;
        pcd_d      = pcd_q;
        pcplus_d   = pcplus_q;
        validd_d   = validd_q;
        flush_take = FlushD || PCSrcE;
        load_take  = 1'b0;
        if (flush_take) begin
            instrd_d = NOP_INSTR;
            validd_d = 1'b0;
        end else if (!StallD) begin
            load_take = 1'b1;
            instrd_d  = imem_data;
            pcd_d     = pcf_q;
            pcplus_d  = pcf_plus;
            validd_d  = fvalid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcf_q    <= RESET_PC;
            boot_q   <= 1'b1;
            instrd_q <= NOP_INSTR;
            pcd_q    <= '0;
            pcplus_q <= '0;
            validd_q <= 1'b0;
        end else begin
            pcf_q    <= pcf_d;
            boot_q   <= 1'b0;
            instrd_q <= instrd_d;
            pcd_q    <= pcd_d;
            pcplus_q <= pcplus_d;
            validd_q <= validd_d;
        end
    end

    assign InstrD       = instrd_q;
    assign PCD          = pcd_q;
    assign PCPlus4D     = pcplus_q;
    assign ValidD       = validd_q;
    assign PCF_debug    = pcf_q;
    assign InstrF_debug = imem_data;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetched_q;
    logic [CNT_W-1:0] flushed_q;
    logic [CNT_W-1:0] stalled_q;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            flushed_q <= '0;
            stalled_q <= '0;
        end else begin
            if (load_take && fvalid && !(&fetched_q)) begin
                fetched_q <= fetched_q + CNT_W'(1);
            end
            if (flush_take && !(&flushed_q)) begin
                flushed_q <= flushed_q + CNT_W'(1);
            end
            if (StallF && !(&stalled_q)) begin
                stalled_q <= stalled_q + CNT_W'(1);
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
    assign perf_stalled = stalled_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_param.sv
`default_nettype none
// Testbench for fetch_stage_param: a 12-bit-PC instance for pipeline control
// and an 8-bit-PC instance with PC_STEP=4 for wrap-around.
module tb_fetch_stage_param;

    localparam int unsigned AW_A = 12;
    localparam int unsigned IW_A = 16;
    localparam logic [IW_A-1:0] NOP_A = 16'h0013;
    localparam int unsigned AW_B = 8;
    localparam int unsigned IW_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Instance A signals
    logic            rst = 1'b0;
    logic            StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [AW_A-1:0] PCTargetE = '0;
    logic [AW_A-1:0] imem_addr;
    logic [IW_A-1:0] imem_data = '0;
    logic [IW_A-1:0] InstrD;
    logic [AW_A-1:0] PCD, PCPlus4D, PCF_debug;
    logic            ValidD;
    logic [IW_A-1:0] InstrF_debug;

    // Instance B signals
    logic            rst_b = 1'b0;
    logic            StallF_b = 1'b0, StallD_b = 1'b0, FlushD_b = 1'b0, PCSrcE_b = 1'b0;
    logic [AW_B-1:0] PCTargetE_b = '0;
    logic [AW_B-1:0] imem_addr_b;
    logic [IW_B-1:0] imem_data_b = '0;
    logic [IW_B-1:0] InstrD_b;
    logic [AW_B-1:0] PCD_b, PCPlus4D_b, PCF_debug_b;
    logic            ValidD_b;
    logic [IW_B-1:0] InstrF_debug_b;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stalled;
    logic [31:0] perf_fetched_b, perf_flushed_b, perf_stalled_b;
`endif

    fetch_stage_param #(
        .AW(AW_A), .IW(IW_A), .PC_STEP(12'd1), .RESET_PC(12'h010), .NOP_INSTR(NOP_A)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .PCF_debug(PCF_debug), .InstrF_debug(InstrF_debug)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed), .perf_stalled(perf_stalled)
`endif
    );

    fetch_stage_param #(
        .AW(AW_B), .IW(IW_B), .PC_STEP(8'd4), .RESET_PC(8'hF4), .NOP_INSTR(8'hFF)
    ) u_dut_b (
        .clk(clk), .rst(rst_b),
        .StallF(StallF_b), .StallD(StallD_b), .FlushD(FlushD_b),
        .PCSrcE(PCSrcE_b), .PCTargetE(PCTargetE_b),
        .imem_addr(imem_addr_b), .imem_data(imem_data_b),
        .InstrD(InstrD_b), .PCD(PCD_b), .PCPlus4D(PCPlus4D_b), .ValidD(ValidD_b),
        .PCF_debug(PCF_debug_b), .InstrF_debug(InstrF_debug_b)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched_b), .perf_flushed(perf_flushed_b), .perf_stalled(perf_stalled_b)
`endif
    );

    // Synchronous instruction memories: word at address a is {4'hA, a} / a ^ 8'h5A.
    always @(posedge clk) begin
        imem_data   <= {4'hA, imem_addr};
        imem_data_b <= imem_addr_b ^ 8'h5A;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #3;
        n_chk++; if (PCF_debug !== 12'h010) $display("FAIL rst_pcf got %h want 010", PCF_debug); else n_pass++;
        n_chk++; if (imem_addr !== 12'h010) $display("FAIL rst_addr got %h want 010", imem_addr); else n_pass++;
        n_chk++; if (InstrD !== NOP_A) $display("FAIL rst_instr got %h want %h", InstrD, NOP_A); else n_pass++;
        n_chk++; if (PCD !== 12'h000) $display("FAIL rst_pcd got %h want 000", PCD); else n_pass++;
        n_chk++; if (PCPlus4D !== 12'h000) $display("FAIL rst_pcp4 got %h want 000", PCPlus4D); else n_pass++;
        n_chk++; if (ValidD !== 1'b0) $display("FAIL rst_valid got %b want 0", ValidD); else n_pass++;
        PCSrcE = 1'b1; PCTargetE = 12'h3AB; #1;
        n_chk++; if (imem_addr !== 12'h010) $display("FAIL rst_addr_redirect got %h want 010", imem_addr); else n_pass++;
        PCSrcE = 1'b0; PCTargetE = '0;
    endtask

    task automatic test_free_run();
        @(negedge clk); rst = 1'b1; #1;
        n_chk++; if (imem_addr !== 12'h010) $display("FAIL boot_addr got %h want 010", imem_addr); else n_pass++;
        step();
        n_chk++; if (PCF_debug !== 12'h010) $display("FAIL boot_pcf got %h want 010", PCF_debug); else n_pass++;
        n_chk++; if (imem_addr !== 12'h011) $display("FAIL run_addr1 got %h want 011", imem_addr); else n_pass++;
        n_chk++; if (ValidD !== 1'b0) $display("FAIL boot_valid got %b want 0", ValidD); else n_pass++;
        step();
        n_chk++; if (imem_addr !== 12'h012) $display("FAIL run_addr2 got %h want 012", imem_addr); else n_pass++;
        n_chk++; if (InstrD !== 16'hA010) $display("FAIL run_instr got %h want A010", InstrD); else n_pass++;
        n_chk++; if (PCD !== 12'h010) $display("FAIL run_pcd got %h want 010", PCD); else n_pass++;
        n_chk++; if (PCPlus4D !== 12'h011) $display("FAIL run_pcp4 got %h want 011", PCPlus4D); else n_pass++;
        n_chk++; if (ValidD !== 1'b1) $display("FAIL run_valid got %b want 1", ValidD); else n_pass++;
        step();
        n_chk++; if (imem_addr !== 12'h013) $display("FAIL run_addr3 got %h want 013", imem_addr); else n_pass++;
        n_chk++; if (PCD !== 12'h011) $display("FAIL run_pcd2 got %h want 011", PCD); else n_pass++;
        step();
        step();
        n_chk++; if (PCF_debug !== 12'h014) $display("FAIL run_pcf got %h want 014", PCF_debug); else n_pass++;
        n_chk++; if (PCD !== 12'h013) $display("FAIL run_pcd3 got %h want 013", PCD); else n_pass++;
    endtask

    task automatic test_redirect();
        PCSrcE = 1'b1; PCTargetE = 12'h200; #1;
        n_chk++; if (imem_addr !== 12'h200) $display("FAIL redir_addr got %h want 200", imem_addr); else n_pass++;
        step(); PCSrcE = 1'b0;
        n_chk++; if (InstrD !== NOP_A) $display("FAIL redir_bubble got %h want %h", InstrD, NOP_A); else n_pass++;
        n_chk++; if (ValidD !== 1'b0) $display("FAIL redir_valid0 got %b want 0", ValidD); else n_pass++;
        n_chk++; if (PCD !== 12'h013) $display("FAIL redir_pcd_hold got %h want 013", PCD); else n_pass++;
        n_chk++; if (PCF_debug !== 12'h200) $display("FAIL redir_pcf got %h want 200", PCF_debug); else n_pass++;
        step();
        n_chk++; if (InstrD !== 16'hA200) $display("FAIL redir_instr got %h want A200", InstrD); else n_pass++;
        n_chk++; if (PCD !== 12'h200) $display("FAIL redir_pcd got %h want 200", PCD); else n_pass++;
        n_chk++; if (PCPlus4D !== 12'h201) $display("FAIL redir_pcp4 got %h want 201", PCPlus4D); else n_pass++;
        n_chk++; if (ValidD !== 1'b1) $display("FAIL redir_valid1 got %b want 1", ValidD); else n_pass++;
    endtask

    task automatic test_stall();
        PCSrcE = 1'b1; PCTargetE = 12'h01E; step(); PCSrcE = 1'b0;
        step(); step();
        n_chk++; if (PCF_debug !== 12'h020) $display("FAIL stall_pre_pcf got %h want 020", PCF_debug); else n_pass++;
        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (imem_addr !== 12'h020) $display("FAIL stall_addr[%0d] got %h want 020", i, imem_addr); else n_pass++;
            n_chk++; if (PCF_debug !== 12'h020) $display("FAIL stall_pcf[%0d] got %h want 020", i, PCF_debug); else n_pass++;
            n_chk++; if (PCD !== 12'h01F) $display("FAIL stall_pcd[%0d] got %h want 01F", i, PCD); else n_pass++;
            n_chk++; if (InstrD !== 16'hA01F) $display("FAIL stall_instr[%0d] got %h want A01F", i, InstrD); else n_pass++;
        end
        StallF = 1'b0; StallD = 1'b0;
        step();
        n_chk++; if (PCD !== 12'h020) $display("FAIL unstall_pcd got %h want 020", PCD); else n_pass++;
        n_chk++; if (InstrD !== 16'hA020) $display("FAIL unstall_instr got %h want A020", InstrD); else n_pass++;
        n_chk++; if (ValidD !== 1'b1) $display("FAIL unstall_valid got %b want 1", ValidD); else n_pass++;
        step();
        n_chk++; if (PCD !== 12'h021) $display("FAIL unstall_pcd2 got %h want 021", PCD); else n_pass++;
        n_chk++; if (InstrD !== 16'hA021) $display("FAIL unstall_instr2 got %h want A021", InstrD); else n_pass++;
    endtask

    task automatic test_flush_stall();
        FlushD = 1'b1; StallD = 1'b1;
        step();
        n_chk++; if (InstrD !== NOP_A) $display("FAIL flush_instr got %h want %h", InstrD, NOP_A); else n_pass++;
        n_chk++; if (ValidD !== 1'b0) $display("FAIL flush_valid got %b want 0", ValidD); else n_pass++;
        n_chk++; if (PCD !== 12'h021) $display("FAIL flush_pcd_hold got %h want 021", PCD); else n_pass++;
        n_chk++; if (PCF_debug !== 12'h023) $display("FAIL flush_pcf_adv got %h want 023", PCF_debug); else n_pass++;
        StallF = 1'b1;
        step();
        n_chk++; if (PCF_debug !== 12'h023) $display("FAIL flush_pcf_hold got %h want 023", PCF_debug); else n_pass++;
        FlushD = 1'b0; StallD = 1'b0; StallF = 1'b0;
        step();
        n_chk++; if (PCD !== 12'h023) $display("FAIL postflush_pcd got %h want 023", PCD); else n_pass++;
        n_chk++; if (InstrD !== 16'hA023) $display("FAIL postflush_instr got %h want A023", InstrD); else n_pass++;
        n_chk++; if (ValidD !== 1'b1) $display("FAIL postflush_valid got %b want 1", ValidD); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        PCSrcE = 1'b1; StallF = 1'b1; StallD = 1'b1; PCTargetE = 12'h300; #1;
        n_chk++; if (imem_addr !== 12'h300) $display("FAIL rs_addr got %h want 300", imem_addr); else n_pass++;
        step(); PCSrcE = 1'b0; StallF = 1'b0; StallD = 1'b0;
        n_chk++; if (PCF_debug !== 12'h300) $display("FAIL rs_pcf got %h want 300", PCF_debug); else n_pass++;
        n_chk++; if (ValidD !== 1'b0) $display("FAIL rs_valid0 got %b want 0", ValidD); else n_pass++;
        step();
        n_chk++; if (PCD !== 12'h300) $display("FAIL rs_pcd got %h want 300", PCD); else n_pass++;
        n_chk++; if (InstrD !== 16'hA300) $display("FAIL rs_instr got %h want A300", InstrD); else n_pass++;
    endtask

    task automatic test_midstream_reset();
        step(); step();
        @(negedge clk); #2; rst = 1'b0; #1;
        n_chk++; if (PCF_debug !== 12'h010) $display("FAIL mrst_pcf got %h want 010", PCF_debug); else n_pass++;
        n_chk++; if (imem_addr !== 12'h010) $display("FAIL mrst_addr got %h want 010", imem_addr); else n_pass++;
        n_chk++; if (InstrD !== NOP_A) $display("FAIL mrst_instr got %h want %h", InstrD, NOP_A); else n_pass++;
        n_chk++; if (PCD !== 12'h000) $display("FAIL mrst_pcd got %h want 000", PCD); else n_pass++;
        n_chk++; if (PCPlus4D !== 12'h000) $display("FAIL mrst_pcp4 got %h want 000", PCPlus4D); else n_pass++;
        n_chk++; if (ValidD !== 1'b0) $display("FAIL mrst_valid got %b want 0", ValidD); else n_pass++;
`ifdef FETCH_PERF_EN
        n_chk++; if (perf_fetched !== 32'd0) $display("FAIL mrst_perf_f got %0d want 0", perf_fetched); else n_pass++;
        n_chk++; if (perf_flushed !== 32'd0) $display("FAIL mrst_perf_fl got %0d want 0", perf_flushed); else n_pass++;
        n_chk++; if (perf_stalled !== 32'd0) $display("FAIL mrst_perf_s got %0d want 0", perf_stalled); else n_pass++;
`endif
        @(negedge clk); rst = 1'b1; #1;
        n_chk++; if (imem_addr !== 12'h010) $display("FAIL rearm_addr got %h want 010", imem_addr); else n_pass++;
        step();
        n_chk++; if (ValidD !== 1'b0) $display("FAIL rearm_valid got %b want 0", ValidD); else n_pass++;
        step();
        n_chk++; if (PCD !== 12'h010) $display("FAIL rearm_pcd got %h want 010", PCD); else n_pass++;
        step();
        StallF = 1'b1; StallD = 1'b1; step(); step();
        StallF = 1'b0; StallD = 1'b0; step();
        FlushD = 1'b1; step(); FlushD = 1'b0;
        step(); step();
        n_chk++; if (PCD !== 12'h015) $display("FAIL script_pcd got %h want 015", PCD); else n_pass++;
        n_chk++; if (ValidD !== 1'b1) $display("FAIL script_valid got %b want 1", ValidD); else n_pass++;
`ifdef FETCH_PERF_EN
        n_chk++; if (perf_fetched !== 32'd5) $display("FAIL perf_fetched got %0d want 5", perf_fetched); else n_pass++;
        n_chk++; if (perf_flushed !== 32'd1) $display("FAIL perf_flushed got %0d want 1", perf_flushed); else n_pass++;
        n_chk++; if (perf_stalled !== 32'd2) $display("FAIL perf_stalled got %0d want 2", perf_stalled); else n_pass++;
`endif
    endtask

    task automatic test_wrap();
        @(negedge clk); rst_b = 1'b1; #1;
        n_chk++; if (imem_addr_b !== 8'hF4) $display("FAIL wrap_boot_addr got %h want F4", imem_addr_b); else n_pass++;
        step();
        n_chk++; if (PCF_debug_b !== 8'hF4) $display("FAIL wrap_pcf0 got %h want F4", PCF_debug_b); else n_pass++;
        step();
        n_chk++; if (PCD_b !== 8'hF4) $display("FAIL wrap_pcd0 got %h want F4", PCD_b); else n_pass++;
        step();
        n_chk++; if (PCF_debug_b !== 8'hFC) $display("FAIL wrap_pcf_fc got %h want FC", PCF_debug_b); else n_pass++;
        n_chk++; if (imem_addr_b !== 8'h00) $display("FAIL wrap_addr got %h want 00", imem_addr_b); else n_pass++;
        step();
        n_chk++; if (PCF_debug_b !== 8'h00) $display("FAIL wrap_pcf got %h want 00", PCF_debug_b); else n_pass++;
        n_chk++; if (PCD_b !== 8'hFC) $display("FAIL wrap_pcd got %h want FC", PCD_b); else n_pass++;
        n_chk++; if (PCPlus4D_b !== 8'h00) $display("FAIL wrap_pcp4 got %h want 00", PCPlus4D_b); else n_pass++;
        n_chk++; if (InstrD_b !== 8'hA6) $display("FAIL wrap_instr got %h want A6", InstrD_b); else n_pass++;
        n_chk++; if (ValidD_b !== 1'b1) $display("FAIL wrap_valid got %b want 1", ValidD_b); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_redirect();
        test_stall();
        test_flush_stall();
        test_redirect_stall();
        test_midstream_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got %0d checks want completion", n_chk);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
